four_bit_comparator: RTL and testbench

Registered magnitude comparator for two WIDTH-bit operands (default 4).
- Produces mutually exclusive equal / less / greater flags, plus max, min and absolute difference.
- Unsigned or two's-complement comparison is selected per sample.
- Sits in datapath control logic wherever a clean, registered compare result with a valid strobe is needed.

---
 rtl/four_bit_comparator.sv | 87 ++++++++
 tb/tb_four_bit_comparator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/four_bit_comparator.sv
// Registered magnitude comparator: equal/less/greater flags plus max, min and
// absolute difference, unsigned or two's-complement selected per sample.
module four_bit_comparator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             signed_mode,
  output logic             a_equal_b,
  output logic             a_less_b,
  output logic             a_greater_b,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] abs_diff,
  output logic             out_valid
);

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  function automatic logic less_than(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic             sgn);
    logic [WIDTH-1:0] xk;
    logic [WIDTH-1:0] yk;
    xk = x;
    yk = y;
    if (sgn) begin
      xk[WIDTH-1] = ~x[WIDTH-1];
      yk[WIDTH-1] = ~y[WIDTH-1];
    end
    return (xk < yk);
  endfunction

  // max - min never exceeds 2^WIDTH-1, so the carry-out bit is always zero.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] mx,
                                                 input logic [WIDTH-1:0] mn);
    return mx - mn;
  endfunction

  logic             eq_d, lt_d, gt_d;
  logic [WIDTH-1:0] max_d, min_d, diff_d;
  logic             eq_q, lt_q, gt_q, vld_q;
  logic [WIDTH-1:0] max_q, min_q, diff_q;

  always_comb begin
    eq_d   = (a == b);
    lt_d   = less_than(a, b, signed_mode);
    gt_d   = !eq_d && !lt_d;
    max_d  = lt_d ? b : a;
    min_d  = lt_d ? a : b;
    diff_d = magnitude(max_d, min_d);
  end

  // Result stage: load on valid samples only, so idle inputs never disturb outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
      max_q  <= '0;
      min_q  <= '0;
      diff_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        eq_q   <= eq_d;
        lt_q   <= lt_d;
        gt_q   <= gt_d;
        max_q  <= max_d;
        min_q  <= min_d;
        diff_q <= diff_d;
      end
    end
  end

  assign a_equal_b   = eq_q;
  assign a_less_b    = lt_q;
  assign a_greater_b = gt_q;
  assign max_out     = max_q;
  assign min_out     = min_q;
  assign abs_diff    = diff_q;
  assign out_valid   = vld_q;

endmodule

// File: tb/tb_four_bit_comparator.sv
// Self-checking bench for four_bit_comparator: directed sweeps plus randomized
// traffic scored against an integer-arithmetic reference model.
module tb_four_bit_comparator;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, signed_mode;
  logic [W-1:0] a, b;
  logic         a_equal_b, a_less_b, a_greater_b, out_valid;
  logic [W-1:0] max_out, min_out, abs_diff;

  int n_cmp  = 0;
  int n_fail = 0;

  four_bit_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .signed_mode(signed_mode), .a_equal_b(a_equal_b), .a_less_b(a_less_b),
    .a_greater_b(a_greater_b), .max_out(max_out), .min_out(min_out),
    .abs_diff(abs_diff), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Packed view: {eq, lt, gt, max, min, diff, valid}
  logic [15:0] obs;
  assign obs = {a_equal_b, a_less_b, a_greater_b, max_out, min_out, abs_diff, out_valid};

  function automatic int to_val(input logic [W-1:0] x, input logic s);
    if (s && x[W-1]) return int'(x) - (1 << W);
    return int'(x);
  endfunction

  function automatic logic [15:0] ref_res(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic s);
    int vx, vy, d;
    logic [W-1:0] mx, mn;
    vx = to_val(x, s);
    vy = to_val(y, s);
    mx = (vx >= vy) ? x : y;
    mn = (vx >= vy) ? y : x;
    d  = (vx > vy) ? vx - vy : vy - vx;
    return {(vx == vy), (vx < vy), (vx > vy), mx, mn, W'(d), 1'b1};
  endfunction

  task automatic drive(input logic r, input logic v, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic s);
    rst = r; in_valid = v; a = x; b = y; signed_mode = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 4'd3, 4'd5, 1'b0);
    n_cmp++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs, 16'h0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'd7, 4'd2, 1'b0);
      n_cmp++;
      if (obs !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs, 16'h0);
      end
    end
  endtask

  task automatic run_sweep(input string name, input logic [W-1:0] xs[4],
                           input logic [W-1:0] ys[4]);
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = ref_res(xs[i], ys[i], 1'b0);
      drive(1'b0, 1'b1, xs[i], ys[i], 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, obs, exp);
      end
    end
  endtask

  task automatic test_less_sweep();
    logic [W-1:0] xs[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic [W-1:0] ys[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    run_sweep("less_sweep", xs, ys);
  endtask

  task automatic test_equal_sweep();
    logic [W-1:0] xs[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    run_sweep("equal_sweep", xs, xs);
  endtask

  task automatic test_greater_sweep();
    logic [W-1:0] xs[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [W-1:0] ys[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    run_sweep("greater_sweep", xs, ys);
  endtask

  task automatic test_mode();
    // Expected values written out by hand: {eq,lt,gt,max,min,diff,vld}
    drive(1'b0, 1'b1, 4'hF, 4'h1, 1'b0);
    n_cmp++;
    if (obs !== {3'b001, 4'hF, 4'h1, 4'hE, 1'b1}) begin
      n_fail++;
      $display("FAIL mode_unsigned: got %h expected %h", obs, {3'b001, 4'hF, 4'h1, 4'hE, 1'b1});
    end
    drive(1'b0, 1'b1, 4'hF, 4'h1, 1'b1);
    n_cmp++;
    if (obs !== {3'b010, 4'h1, 4'hF, 4'h2, 1'b1}) begin
      n_fail++;
      $display("FAIL mode_signed: got %h expected %h", obs, {3'b010, 4'h1, 4'hF, 4'h2, 1'b1});
    end
    drive(1'b0, 1'b1, 4'h8, 4'h7, 1'b1);
    n_cmp++;
    if (obs !== {3'b010, 4'h7, 4'h8, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL mode_signed_extreme: got %h expected %h", obs, {3'b010, 4'h7, 4'h8, 4'hF, 1'b1});
    end
  endtask

  task automatic test_hold_reset();
    logic [15:0] exp;
    exp = {3'b001, 4'd5, 4'd3, 4'd2, 1'b1};
    drive(1'b0, 1'b1, 4'd5, 4'd3, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hold_load: got %h expected %h", obs, exp);
    end
    exp[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 'x, 'x, 1'bx);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    drive(1'b1, 1'b1, 4'd9, 4'd9, 1'b0);
    n_cmp++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_midstream: got %h expected %h", obs, 16'h0);
    end
    exp = {3'b010, 4'd6, 4'd2, 4'd4, 1'b1};
    drive(1'b0, 1'b1, 4'd2, 4'd6, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL after_reset: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic [W-1:0] x, y;
    logic s, v, r;
    exp = obs;
    // Seed the model from a known point: one reset edge first.
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    exp = 16'h0;
    for (int i = 0; i < 300; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      s = 1'($urandom);
      v = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 49) == 0);
      if (r)      exp = 16'h0;
      else if (v) exp = ref_res(x, y, s);
      else        exp[0] = 1'b0;
      drive(r, v, x, y, s);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h s=%b v=%b r=%b: got %h expected %h",
                 i, x, y, s, v, r, obs, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    @(negedge clk);
    test_reset();
    test_less_sweep();
    test_equal_sweep();
    test_greater_sweep();
    test_mode();
    test_hold_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
